// File: rtl/tt_input_debounce.sv
// tt_input_debounce: per-bit synchroniser, consecutive-cycle debounce filter and rise/fall pulses.
// Optional: define TT_DEBOUNCE_GLITCH_CNT_EN to add the saturating 8-bit glitch_count output.
module tt_input_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
`ifdef TT_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0]       glitch_count
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] commit;

    // Synchroniser runs regardless of en so the filter never sees stale data on re-enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        commit = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync[i] != stable_out[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    commit[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_out <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else if (en) begin
            stable_out <= stable_out ^ commit;
            rise_pulse <= commit & sync;
            fall_pulse <= commit & ~sync;
            any_change <= |commit;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end else begin
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end
    end

`ifdef TT_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_sat;

    // An abort is a partially counted mismatch that the input abandoned before committing.
    always_comb begin
        int unsigned total;
        total = 32'(glitch_count);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if ((cnt[i] != '0) && (sync[i] == stable_out[i])) begin
                total = total + 1;
            end
        end
        glitch_sat = (total > 255) ? 8'hFF : total[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_count <= '0;
        end else if (en) begin
            glitch_count <= glitch_sat;
        end
    end
`endif

endmodule

// File: tb/tb_tt_input_debounce.sv
// Scoreboard bench for tt_input_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected outputs are queued per cycle when stimulus is driven and compared on the falling edge.
module tb_tt_input_debounce;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] raw_in;
    logic [7:0] stable_out;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic       any_change;
`ifdef TT_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    tt_input_debounce #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .raw_in(raw_in),
        .stable_out(stable_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .any_change(any_change)
`ifdef TT_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_count(glitch_count)
`endif
    );

    typedef struct {
        int unsigned cyc;
        logic [7:0]  stable;
        logic [7:0]  rise;
        logic [7:0]  fall;
        logic        anyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic sb_push(input int unsigned c, input logic [7:0] s, input logic [7:0] r,
                           input logic [7:0] f, input logic a, input string name);
        exp_t e;
        e.cyc = c; e.stable = s; e.rise = r; e.fall = f; e.anyc = a; e.name = name;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".stable"}, 32'(stable_out), 32'h0);
        check_eq({tag, ".rise"}, 32'(rise_pulse), 32'h0);
        check_eq({tag, ".fall"}, 32'(fall_pulse), 32'h0);
        check_eq({tag, ".any"}, 32'(any_change), 32'h0);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc < cyc) begin
                check_eq({mon_e.name, ".late"}, mon_e.cyc, cyc);
            end else begin
                check_eq({mon_e.name, ".stable"}, 32'(stable_out), 32'(mon_e.stable));
                check_eq({mon_e.name, ".rise"}, 32'(rise_pulse), 32'(mon_e.rise));
                check_eq({mon_e.name, ".fall"}, 32'(fall_pulse), 32'(mon_e.fall));
                check_eq({mon_e.name, ".any"}, 32'(any_change), 32'(mon_e.anyc));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;

        rst_n = 1'b0; en = 1'b1; raw_in = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
`ifdef TT_DEBOUNCE_GLITCH_CNT_EN
        check_eq("reset.glitch", 32'(glitch_count), 32'h0);
`endif

        // Release with all pins high: six edges until the 0->1 commit.
        n = cyc;
        rst_n = 1'b1;
        sb_push(n + 5, 8'h00, 8'h00, 8'h00, 1'b0, "lat_pre");
        sb_push(n + 6, 8'hFF, 8'hFF, 8'h00, 1'b1, "lat_rise");
        sb_push(n + 7, 8'hFF, 8'h00, 8'h00, 1'b0, "lat_post");
        repeat (8) @(negedge clk);

        n = cyc;
        raw_in = 8'h00;
        sb_push(n + 6, 8'h00, 8'h00, 8'hFF, 1'b1, "to_zero");
        sb_push(n + 7, 8'h00, 8'h00, 8'h00, 1'b0, "to_zero_post");
        repeat (8) @(negedge clk);

        // Three-cycle glitch on bit 3 must be rejected.
        n = cyc;
        raw_in = 8'h08;
        sb_push(n + 3, 8'h00, 8'h00, 8'h00, 1'b0, "rej_a");
        sb_push(n + 5, 8'h00, 8'h00, 8'h00, 1'b0, "rej_b");
        sb_push(n + 6, 8'h00, 8'h00, 8'h00, 1'b0, "rej_c");
        sb_push(n + 8, 8'h00, 8'h00, 8'h00, 1'b0, "rej_d");
        repeat (3) @(negedge clk);
        raw_in = 8'h00;
        repeat (7) @(negedge clk);
`ifdef TT_DEBOUNCE_GLITCH_CNT_EN
        check_eq("rej.glitch", 32'(glitch_count), 32'h1);
`endif

        // Four-cycle pulse on bit 3 is accepted and held for four cycles.
        n = cyc;
        raw_in = 8'h08;
        sb_push(n + 5,  8'h00, 8'h00, 8'h00, 1'b0, "acc_pre");
        sb_push(n + 6,  8'h08, 8'h08, 8'h00, 1'b1, "acc_rise");
        sb_push(n + 7,  8'h08, 8'h00, 8'h00, 1'b0, "acc_hold1");
        sb_push(n + 9,  8'h08, 8'h00, 8'h00, 1'b0, "acc_hold4");
        sb_push(n + 10, 8'h00, 8'h00, 8'h08, 1'b1, "acc_fall");
        sb_push(n + 11, 8'h00, 8'h00, 8'h00, 1'b0, "acc_post");
        repeat (4) @(negedge clk);
        raw_in = 8'h00;
        repeat (8) @(negedge clk);

        n = cyc;
        raw_in = 8'h0F;
        sb_push(n + 6, 8'h0F, 8'h0F, 8'h00, 1'b1, "to_0f");
        repeat (8) @(negedge clk);

        // Four bits rise and four fall on the same edge.
        n = cyc;
        raw_in = 8'hF0;
        sb_push(n + 5, 8'h0F, 8'h00, 8'h00, 1'b0, "sim_pre");
        sb_push(n + 6, 8'hF0, 8'hF0, 8'h0F, 1'b1, "sim_commit");
        sb_push(n + 7, 8'hF0, 8'h00, 8'h00, 1'b0, "sim_post");
        repeat (8) @(negedge clk);

        // Disable after two counted mismatch cycles; two more edges needed after re-enable.
        n = cyc;
        raw_in = 8'hFF;
        repeat (4) @(negedge clk);
        en = 1'b0;
        sb_push(n + 6,  8'hF0, 8'h00, 8'h00, 1'b0, "en_off_a");
        sb_push(n + 10, 8'hF0, 8'h00, 8'h00, 1'b0, "en_off_b");
        sb_push(n + 14, 8'hF0, 8'h00, 8'h00, 1'b0, "en_off_c");
        sb_push(n + 15, 8'hF0, 8'h00, 8'h00, 1'b0, "en_resume");
        sb_push(n + 16, 8'hFF, 8'h0F, 8'h00, 1'b1, "en_commit");
        sb_push(n + 17, 8'hFF, 8'h00, 8'h00, 1'b0, "en_post");
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);

        // Asynchronous reset between edges while a 1->0 count is in flight.
        raw_in = 8'h00;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
`ifdef TT_DEBOUNCE_GLITCH_CNT_EN
        check_eq("async_rst.glitch", 32'(glitch_count), 32'h0);
`endif
        raw_in = 8'hFF;
        @(negedge clk);
        n = cyc;
        rst_n = 1'b1;
        sb_push(n + 5, 8'h00, 8'h00, 8'h00, 1'b0, "post_rst_pre");
        sb_push(n + 6, 8'hFF, 8'hFF, 8'h00, 1'b1, "post_rst_rise");
        sb_push(n + 7, 8'hFF, 8'h00, 8'h00, 1'b0, "post_rst_post");
        repeat (9) @(negedge clk);

        check_eq("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
